// File: rtl/fpro_bridge_pkg.sv
// rtl/fpro_bridge_pkg.sv - shared types and constants for the MCS-to-FPro bridge
package fpro_bridge_pkg;

    localparam int MMIO_ADDR_W = 21;
    localparam int DATA_W      = 32;

    localparam logic [DATA_W-1:0] UNMAPPED_RD_VALUE = 32'h0;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_RD,
        WAIT_RD,
        ISSUE_WR,
        ACK
    } state_t;

endpackage

// File: rtl/fpro_byte_merge.sv
// rtl/fpro_byte_merge.sv - byte-lane merge of new write data over previously read data
module fpro_byte_merge
    import fpro_bridge_pkg::*;
(
    input  logic [DATA_W-1:0] old_data,
    input  logic [DATA_W-1:0] new_data,
    input  logic [3:0]        byte_en,
    output logic [DATA_W-1:0] merged
);

    always_comb begin
        merged = old_data;
        for (int i = 0; i < 4; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mcs_fpro_bridge.sv
// rtl/mcs_fpro_bridge.sv - MCS IO-bus to FPro MMIO bridge; BRIDGE_BYTE_RMW_EN enables byte-lane read-modify-write
module mcs_fpro_bridge
    import fpro_bridge_pkg::*;
#(
    parameter logic [1:0] MMIO_BASE  = 2'b11,
    parameter int         RD_LATENCY = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   io_addr_strobe,
    input  logic                   io_read_strobe,
    input  logic                   io_write_strobe,
    input  logic [3:0]             io_byte_enable,
    input  logic [31:0]            io_address,
    input  logic [DATA_W-1:0]      io_write_data,
    output logic [DATA_W-1:0]      io_read_data,
    output logic                   io_ready,
    output logic                   mmio_cs,
    output logic                   mmio_read,
    output logic                   mmio_write,
    output logic [MMIO_ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0]      mmio_wr_data,
    input  logic [DATA_W-1:0]      mmio_rd_data,
    output logic                   bus_err,
    input  logic                   err_clr
);

    localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [MMIO_ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      io_read_data_q, io_read_data_d;
    logic                   bus_err_q, bus_err_d;
    logic                   io_ready_q, io_ready_d;
    logic                   mmio_cs_q, mmio_cs_d;
    logic                   mmio_read_q, mmio_read_d;
    logic                   mmio_write_q, mmio_write_d;
    logic [MMIO_ADDR_W-1:0] mmio_addr_q, mmio_addr_d;
    logic [DATA_W-1:0]      mmio_wr_data_q, mmio_wr_data_d;
    logic                   hit, start, sample, err_set;
    logic                   unused_bits;

    assign hit   = (io_address[31:30] == MMIO_BASE);
    assign start = io_addr_strobe & (io_read_strobe | io_write_strobe);

`ifdef BRIDGE_BYTE_RMW_EN
    logic              rmw_q, rmw_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] merged;

    fpro_byte_merge u_merge (
        .old_data (mmio_rd_data),
        .new_data (wdata_q),
        .byte_en  (be_q),
        .merged   (merged)
    );

    assign unused_bits = ^{io_address[29:23], io_address[1:0]};
`else
    assign unused_bits = ^{io_address[29:23], io_address[1:0], io_byte_enable};
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            io_read_data_q <= '0;
            bus_err_q      <= 1'b0;
            io_ready_q     <= 1'b0;
            mmio_cs_q      <= 1'b0;
            mmio_read_q    <= 1'b0;
            mmio_write_q   <= 1'b0;
            mmio_addr_q    <= '0;
            mmio_wr_data_q <= '0;
`ifdef BRIDGE_BYTE_RMW_EN
            rmw_q          <= 1'b0;
            be_q           <= '0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            io_read_data_q <= io_read_data_d;
            bus_err_q      <= bus_err_d;
            io_ready_q     <= io_ready_d;
            mmio_cs_q      <= mmio_cs_d;
            mmio_read_q    <= mmio_read_d;
            mmio_write_q   <= mmio_write_d;
            mmio_addr_q    <= mmio_addr_d;
            mmio_wr_data_q <= mmio_wr_data_d;
`ifdef BRIDGE_BYTE_RMW_EN
            rmw_q          <= rmw_d;
            be_q           <= be_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        io_read_data_d = io_read_data_q;
        sample         = 1'b0;
        err_set        = 1'b0;
`ifdef BRIDGE_BYTE_RMW_EN
        rmw_d          = rmw_q;
        be_d           = be_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d  = io_address[22:2];
                    wdata_d = io_write_data;
`ifdef BRIDGE_BYTE_RMW_EN
                    rmw_d   = 1'b0;
                    be_d    = io_byte_enable;
`endif
                    // A combined read+write strobe performs the write only
                    if (io_read_strobe && io_write_strobe) begin
                        err_set = 1'b1;
                    end
                    if (!hit) begin
                        err_set        = 1'b1;
                        io_read_data_d = UNMAPPED_RD_VALUE;
                        state_d        = ACK;
                    end else if (io_write_strobe) begin
`ifdef BRIDGE_BYTE_RMW_EN
                        if (io_byte_enable == 4'h0) begin
                            io_read_data_d = '0;
                            state_d        = ACK;
                        end else if (io_byte_enable != 4'hF) begin
                            rmw_d   = 1'b1;
                            state_d = ISSUE_RD;
                        end else begin
                            state_d = ISSUE_WR;
                        end
`else
                        state_d = ISSUE_WR;
`endif
                    end else begin
                        state_d = ISSUE_RD;
                    end
                end
            end
            ISSUE_RD: begin
                if (RD_LAT == 3'd0) begin
                    sample = 1'b1;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (cnt_q == RD_LAT) begin
                    sample = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ISSUE_WR: begin
                io_read_data_d = '0;
                state_d        = ACK;
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (sample) begin
`ifdef BRIDGE_BYTE_RMW_EN
            if (rmw_q) begin
                wdata_d = merged;
                state_d = ISSUE_WR;
            end else begin
                io_read_data_d = mmio_rd_data;
                state_d        = ACK;
            end
`else
            io_read_data_d = mmio_rd_data;
            state_d        = ACK;
`endif
        end

        if (io_addr_strobe && (state_q != IDLE)) begin
            err_set = 1'b1;
        end
        bus_err_d = err_set | (bus_err_q & ~err_clr);
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it
    always_comb begin
        io_ready_d     = (state_d == ACK);
        mmio_read_d    = (state_d == ISSUE_RD);
        mmio_write_d   = (state_d == ISSUE_WR);
        mmio_cs_d      = mmio_read_d | mmio_write_d;
        mmio_addr_d    = (state_d inside {ISSUE_RD, WAIT_RD, ISSUE_WR}) ? addr_d : '0;
        mmio_wr_data_d = (state_d == ISSUE_WR) ? wdata_d : '0;
    end

    assign io_read_data = io_read_data_q;
    assign io_ready     = io_ready_q;
    assign mmio_cs      = mmio_cs_q;
    assign mmio_read    = mmio_read_q;
    assign mmio_write   = mmio_write_q;
    assign mmio_addr    = mmio_addr_q;
    assign mmio_wr_data = mmio_wr_data_q;
    assign bus_err      = bus_err_q;

endmodule

// File: tb/tb_mcs_fpro_bridge.sv
// tb/tb_mcs_fpro_bridge.sv - directed vector bench for mcs_fpro_bridge
module tb_mcs_fpro_bridge;

    localparam int RDL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        io_addr_strobe = 1'b0;
    logic        io_read_strobe = 1'b0;
    logic        io_write_strobe = 1'b0;
    logic [3:0]  io_byte_enable = 4'h0;
    logic [31:0] io_address = '0;
    logic [31:0] io_write_data = '0;
    logic [31:0] io_read_data;
    logic        io_ready;
    logic        mmio_cs;
    logic        mmio_read;
    logic        mmio_write;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] mmio_rd_data = '0;
    logic        bus_err;
    logic        err_clr = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    mcs_fpro_bridge #(.MMIO_BASE(2'b11), .RD_LATENCY(RDL)) dut (
        .clk             (clk),
        .reset           (reset),
        .io_addr_strobe  (io_addr_strobe),
        .io_read_strobe  (io_read_strobe),
        .io_write_strobe (io_write_strobe),
        .io_byte_enable  (io_byte_enable),
        .io_address      (io_address),
        .io_write_data   (io_write_data),
        .io_read_data    (io_read_data),
        .io_ready        (io_ready),
        .mmio_cs         (mmio_cs),
        .mmio_read       (mmio_read),
        .mmio_write      (mmio_write),
        .mmio_addr       (mmio_addr),
        .mmio_wr_data    (mmio_wr_data),
        .mmio_rd_data    (mmio_rd_data),
        .bus_err         (bus_err),
        .err_clr         (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          rd;
        bit          wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] slot;
        int          dup_cyc;
        int          e_rd;
        int          e_wr;
        int          e_rdy;
        logic [20:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;
        bit          e_err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int          cyc_rd, cyc_wr, cyc_rdy, n_rdy;
        logic [20:0] got_addr;
        logic [31:0] got_wdata, got_rdata;
        bit          overlap;
        cyc_rd = -1; cyc_wr = -1; cyc_rdy = -1; n_rdy = 0;
        got_addr = '0; got_wdata = '0; got_rdata = '0; overlap = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            io_addr_strobe  = (c == 0) || (c == v.dup_cyc);
            io_read_strobe  = (c == 0) && v.rd;
            io_write_strobe = ((c == 0) && v.wr) || (c == v.dup_cyc);
            io_byte_enable  = (c == 0) ? v.be : 4'h0;
            io_address      = (c == 0) ? v.addr : ((c == v.dup_cyc) ? 32'hC000_0200 : 32'h0);
            io_write_data   = (c == 0) ? v.wdata : 32'h0;
            mmio_rd_data    = (c == 1 + RDL) ? v.slot : 32'hDEAD_BEEF;
            @(negedge clk);
            if (mmio_read && cyc_rd < 0) begin
                cyc_rd = c;
                got_addr = mmio_addr;
            end
            if (mmio_write && cyc_wr < 0) begin
                cyc_wr = c;
                got_wdata = mmio_wr_data;
                if (cyc_rd < 0) got_addr = mmio_addr;
            end
            if (io_ready) begin
                n_rdy++;
                if (cyc_rdy < 0) begin
                    cyc_rdy = c;
                    got_rdata = io_read_data;
                end
                if (mmio_cs || mmio_read || mmio_write) overlap = 1;
            end
        end
        chk({v.name, ".rd_cycle"}, 32'(cyc_rd), 32'(v.e_rd));
        chk({v.name, ".wr_cycle"}, 32'(cyc_wr), 32'(v.e_wr));
        chk({v.name, ".ready_cycle"}, 32'(cyc_rdy), 32'(v.e_rdy));
        chk({v.name, ".ready_count"}, 32'(n_rdy), 32'd1);
        chk({v.name, ".mmio_addr"}, {11'b0, got_addr}, {11'b0, v.e_addr});
        chk({v.name, ".mmio_wr_data"}, got_wdata, v.e_wdata);
        chk({v.name, ".io_read_data"}, got_rdata, v.e_rdata);
        chk({v.name, ".ready_overlap"}, {31'b0, overlap}, 32'd0);
        chk({v.name, ".bus_err"}, {31'b0, bus_err}, {31'b0, v.e_err});
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        chk({v.name, ".bus_err_clr"}, {31'b0, bus_err}, 32'd0);
    endtask

    function automatic logic outs_any();
        return |{io_read_data, io_ready, mmio_cs, mmio_read, mmio_write,
                 mmio_addr, mmio_wr_data, bus_err};
    endfunction

    initial begin
        int n_rdy;
        vecs[0] = '{"wr_full",    0, 1, 4'hF, 32'hC000_0A04, 32'h0000_00A5, 32'h0,          -1,
                    -1,  1, 2, 21'h000281, 32'h0000_00A5, 32'h0,          0};
        vecs[1] = '{"rd_lat",     1, 0, 4'hF, 32'hC000_0100, 32'h0,          32'h1234_5678, -1,
                     1, -1, 4, 21'h000040, 32'h0,          32'h1234_5678, 0};
        vecs[2] = '{"rd_miss",    1, 0, 4'hF, 32'h4000_0000, 32'h0,          32'h1111_1111, -1,
                    -1, -1, 1, 21'h0,      32'h0,          32'h0,          1};
        vecs[3] = '{"rd_top",     1, 0, 4'hF, 32'hC07F_FFFC, 32'h0,          32'hFFFF_0001, -1,
                     1, -1, 4, 21'h1FFFFF, 32'h0,          32'hFFFF_0001, 0};
        vecs[4] = '{"wr_miss",    0, 1, 4'hF, 32'h8000_0010, 32'h0000_0001, 32'h0,          -1,
                    -1, -1, 1, 21'h0,      32'h0,          32'h0,          1};
        vecs[5] = '{"rd_hi_bits", 1, 0, 4'hF, 32'hFF80_0000, 32'h0,          32'hCAFE_F00D, -1,
                     1, -1, 4, 21'h0,      32'h0,          32'hCAFE_F00D, 0};
        vecs[6] = '{"rd_wr_both", 1, 1, 4'hF, 32'hC000_1000, 32'h5555_AAAA, 32'h0,          -1,
                    -1,  1, 2, 21'h000400, 32'h5555_AAAA, 32'h0,          1};
        vecs[7] = '{"rd_dup",     1, 0, 4'hF, 32'hC000_0100, 32'h0,          32'h0BAD_CAFE, 2,
                     1, -1, 4, 21'h000040, 32'h0,          32'h0BAD_CAFE, 1};
`ifdef BRIDGE_BYTE_RMW_EN
        vecs[8] = '{"wr_rmw",     0, 1, 4'h3, 32'hC000_0008, 32'h1122_3344, 32'hAABB_CCDD, -1,
                     1,  4, 5, 21'h000002, 32'hAABB_3344, 32'h0,          0};
        vecs[9] = '{"wr_be0",     0, 1, 4'h0, 32'hC000_000C, 32'h0000_0077, 32'h0,          -1,
                    -1, -1, 1, 21'h0,      32'h0,          32'h0,          0};
`else
        vecs[8] = '{"wr_part",    0, 1, 4'h3, 32'hC000_0008, 32'h1122_3344, 32'hAABB_CCDD, -1,
                    -1,  1, 2, 21'h000002, 32'h1122_3344, 32'h0,          0};
        vecs[9] = '{"wr_be0",     0, 1, 4'h0, 32'hC000_000C, 32'h0000_0077, 32'h0,          -1,
                    -1,  1, 2, 21'h000003, 32'h0000_0077, 32'h0,          0};
`endif

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {31'b0, outs_any()}, 32'd0);
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("post_reset_outputs", {31'b0, outs_any()}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end

        // Error set wins over a simultaneous clear
        @(posedge clk); #1;
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = 32'h0000_0040; err_clr = 1'b1;
        @(posedge clk); #1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_address = '0; err_clr = 1'b0;
        @(negedge clk);
        chk("set_over_clr.bus_err", {31'b0, bus_err}, 32'd1);
        chk("set_over_clr.ready", {31'b0, io_ready}, 32'd1);
        @(negedge clk);
        chk("sticky.bus_err", {31'b0, bus_err}, 32'd1);

        // Reset while waiting for read data drops the transaction
        @(posedge clk); #1;
        io_addr_strobe = 1'b1; io_read_strobe = 1'b1; io_address = 32'hC000_0100;
        mmio_rd_data = 32'h7777_7777;
        @(posedge clk); #1;
        io_addr_strobe = 1'b0; io_read_strobe = 1'b0; io_address = '0;
        @(negedge clk);
        chk("rst_seq.read_issued", {31'b0, mmio_read}, 32'd1);
        @(posedge clk); #1; reset = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(negedge clk);
        chk("rst_seq.outputs_zero", {31'b0, outs_any()}, 32'd0);
        n_rdy = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (io_ready) n_rdy++;
        end
        chk("rst_seq.no_ready", 32'(n_rdy), 32'd0);
        run_vec(vecs[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
